// File: rtl/xyz_pkg.sv
// Shared types and constants for the x/y/z frame transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package xyz_pkg;

   localparam int FRAME_LEN = 15;
   localparam int PAY_LEN   = 12;

   localparam logic [7:0] HDR0_DEF = 8'hA5;
   localparam logic [7:0] HDR1_DEF = 8'h5A;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND_H0,
      ST_SEND_H1,
      ST_SEND_PAY,
      ST_SEND_CS
   } state_e;

   // x occupies the most significant bits so payload byte 0 is x[31:24]
   typedef struct packed {
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] z;
   } triple_t;

   // Big-endian payload byte selection: idx 0..11 walks x, y, z MSB first
   function automatic logic [7:0] pay_byte(input triple_t t, input logic [3:0] idx);
      logic [95:0] sh;
      sh = t << {idx, 3'b000};
      return sh[95:88];
   endfunction

endpackage

// File: rtl/xyz_frame_buf.sv
// One-deep pending triple slot with latest-wins overwrite and saturating drop counter.
// Latency: stored triple visible one cycle after push; full/drop_cnt registered.
// Backpressure: never stalls; an overwrite of a full slot (without a same-cycle pop) counts a drop.
module xyz_frame_buf
   import xyz_pkg::*;
#(
   parameter int DROP_W = 8
) (
   input  logic              clk50,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic              clr,
   input  triple_t           din,
   output triple_t           dout,
   output logic              full,
   output logic              full_nxt,
   output logic [DROP_W-1:0] drop_cnt
);

   triple_t           slot_q, slot_d;
   logic              full_q, full_d;
   logic [DROP_W-1:0] drop_q, drop_d;

   // Next slot contents, occupancy and drop count; clr dominates push and pop
   always_comb begin
      slot_d = slot_q;
      full_d = full_q;
      drop_d = drop_q;
      if (clr) begin
         full_d = 1'b0;
         drop_d = '0;
      end else if (push) begin
         slot_d = din;
         full_d = 1'b1;
         // A push onto a slot that is being popped this cycle is a refill, not a loss
         if (full_q && !pop && (drop_q != {DROP_W{1'b1}})) begin
            drop_d = drop_q + 1'b1;
         end
      end else if (pop) begin
         full_d = 1'b0;
      end
   end

   // Slot state registers
   always_ff @(posedge clk50 or posedge rst) begin
      if (rst) begin
         slot_q <= '0;
         full_q <= 1'b0;
         drop_q <= '0;
      end else begin
         slot_q <= slot_d;
         full_q <= full_d;
         drop_q <= drop_d;
      end
   end

   assign dout     = slot_q;
   assign full     = full_q;
   assign full_nxt = full_d;
   assign drop_cnt = drop_q;

endmodule

// File: rtl/xyz_frame_tx.sv
// Serialises x/y/z triples into 15-byte frames (HDR0 HDR1 12 payload bytes CSUM).
// Latency: valid in cycle t from IDLE gives tx_valid with HDR0 in cycle t+1; one byte per handshake.
// Backpressure: tx_valid/tx_data held until tx_ready; one triple queued, newer ones overwrite it.
module xyz_frame_tx
   import xyz_pkg::*;
#(
   parameter logic [7:0] HDR0   = HDR0_DEF,
   parameter logic [7:0] HDR1   = HDR1_DEF,
   parameter int         DROP_W = 8
) (
   input  logic              clk50,
   input  logic              rst,
   input  logic [31:0]       x,
   input  logic [31:0]       y,
   input  logic [31:0]       z,
   input  logic              valid,
   input  logic              clr,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              busy,
   output logic [DROP_W-1:0] drop_cnt
);

   state_e     state_q, state_d;
   logic [3:0] idx_q, idx_d;
   logic [7:0] csum_q, csum_d;
   triple_t    active_q, active_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic       tx_valid_q, tx_valid_d;
   logic       busy_q, busy_d;

   triple_t    in_t;
   triple_t    pend_t;
   logic       pend_full;
   logic       pend_full_nxt;
   logic       hs;
   logic       pop;
   logic       direct;
   logic       push;

   assign in_t = '{x: x, y: y, z: z};
   assign hs   = tx_valid_q & tx_ready;

   // New triples go to the slot whenever the FSM cannot take them itself
   assign push = valid & ~clr & (state_q != ST_IDLE) & ~direct;

   xyz_frame_buf #(
      .DROP_W (DROP_W)
   ) u_buf (
      .clk50    (clk50),
      .rst      (rst),
      .push     (push),
      .pop      (pop),
      .clr      (clr),
      .din      (in_t),
      .dout     (pend_t),
      .full     (pend_full),
      .full_nxt (pend_full_nxt),
      .drop_cnt (drop_cnt)
   );

   // Next state, active triple, checksum, and the registered byte presented next cycle
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      csum_d     = csum_q;
      active_d   = active_q;
      pop        = 1'b0;
      direct     = 1'b0;
      tx_valid_d = 1'b0;
      tx_data_d  = 8'h00;
      busy_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // A valid in IDLE starts a frame even when clr is asserted with it
            if (valid) begin
               active_d = in_t;
               state_d  = ST_SEND_H0;
            end
         end
         ST_SEND_H0: begin
            if (hs) state_d = ST_SEND_H1;
         end
         ST_SEND_H1: begin
            if (hs) begin
               state_d = ST_SEND_PAY;
               idx_d   = 4'd0;
            end
         end
         ST_SEND_PAY: begin
            if (hs) begin
               csum_d = csum_q + pay_byte(active_q, idx_q);
               if (idx_q == 4'(PAY_LEN - 1)) begin
                  state_d = ST_SEND_CS;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         ST_SEND_CS: begin
            if (hs) begin
               // Pending triple has priority; a same-cycle arrival then refills the slot
               if (pend_full && !clr) begin
                  pop      = 1'b1;
                  active_d = pend_t;
                  state_d  = ST_SEND_H0;
               end else if (valid && !clr) begin
                  direct   = 1'b1;
                  active_d = in_t;
                  state_d  = ST_SEND_H0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if ((state_d == ST_SEND_H0) && (state_q != ST_SEND_H0)) begin
         csum_d = 8'h00;
      end

      // Output byte is derived from the next state so it is registered and stable while stalled
      tx_valid_d = (state_d != ST_IDLE);
      case (state_d)
         ST_SEND_H0:  tx_data_d = HDR0;
         ST_SEND_H1:  tx_data_d = HDR1;
         ST_SEND_PAY: tx_data_d = pay_byte(active_d, idx_d);
         ST_SEND_CS:  tx_data_d = csum_d;
         default:     tx_data_d = 8'h00;
      endcase

      busy_d = (state_d != ST_IDLE) | pend_full_nxt;
   end

   // Frame state and output registers
   always_ff @(posedge clk50 or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         idx_q      <= 4'd0;
         csum_q     <= 8'h00;
         active_q   <= '0;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         csum_q     <= csum_d;
         active_q   <= active_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         busy_q     <= busy_d;
      end
   end

   assign tx_data  = tx_data_q;
   assign tx_valid = tx_valid_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_xyz_frame_tx.sv
module tb_xyz_frame_tx;
   import xyz_pkg::*;

   logic        clk50 = 1'b0;
   logic        rst;
   logic [31:0] x, y, z;
   logic        valid;
   logic        clr;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;
   logic [7:0]  drop_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] exp_q[$];
   int ready_mode = 0;   // 0: always ready, 1: ready one cycle in three, 2: never ready

   always #5 clk50 = ~clk50;

   xyz_frame_tx #(
      .HDR0   (8'hA5),
      .HDR1   (8'h5A),
      .DROP_W (8)
   ) dut (
      .clk50    (clk50),
      .rst      (rst),
      .x        (x),
      .y        (y),
      .z        (z),
      .valid    (valid),
      .clr      (clr),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .busy     (busy),
      .drop_cnt (drop_cnt)
   );

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   // Expected frame bytes, independently assembled; nbytes < 15 for a frame cut short
   function automatic void push_frame(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c, input int nbytes);
      logic [7:0]  f[FRAME_LEN];
      logic [95:0] p;
      logic [7:0]  s;
      p = {a, b, c};
      s = 8'h00;
      f[0] = 8'hA5;
      f[1] = 8'h5A;
      for (int i = 0; i < 12; i++) begin
         f[2+i] = p[95-8*i -: 8];
         s = s + f[2+i];
      end
      f[14] = s;
      for (int i = 0; i < nbytes; i++) exp_q.push_back(f[i]);
   endfunction

   task automatic tick();
      @(posedge clk50);
      #1;
   endtask

   // Valid held for exactly one capture edge per call
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      x = a; y = b; z = c; valid = 1'b1;
      @(posedge clk50);
      #1;
      valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || busy !== 1'b0) && k < budget) begin
         @(negedge clk50);
         k++;
      end
      chk("drain_left", exp_q.size(), 0);
      chk("drain_busy", busy, 0);
      tick();
   endtask

   // Ready pattern driver
   initial begin
      int rcnt;
      rcnt = 0;
      tx_ready = 1'b1;
      forever begin
         @(posedge clk50);
         #1;
         case (ready_mode)
            0: tx_ready = 1'b1;
            1: begin tx_ready = (rcnt % 3 == 0); rcnt++; end
            default: tx_ready = 1'b0;
         endcase
      end
   end

   // Monitor: pops expected bytes on handshakes, checks stall stability and no-bubble streaming
   initial begin
      logic       prev_stall;
      logic       prev_hs;
      logic [7:0] prev_dat;
      prev_stall = 1'b0;
      prev_hs    = 1'b0;
      prev_dat   = 8'h00;
      forever begin
         @(negedge clk50);
         if (rst) begin
            prev_stall = 1'b0;
            prev_hs    = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("hold_vld", tx_valid, 1);
               chk("hold_dat", tx_data, prev_dat);
            end
            if (prev_hs && exp_q.size() > 0 && tx_ready) chk("no_bubble", tx_valid, 1);
            if (tx_valid && tx_ready) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_byte: got %0h expected none", tx_data);
               end else begin
                  chk("byte", tx_data, exp_q.pop_front());
               end
            end
            prev_hs    = tx_valid && tx_ready;
            prev_stall = tx_valid && !tx_ready;
            prev_dat   = tx_data;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; valid = 1'b0; clr = 1'b0;
      x = '0; y = '0; z = '0;
      #1;
      chk("rst_vld",  tx_valid, 0);
      chk("rst_dat",  tx_data,  0);
      chk("rst_busy", busy,     0);
      chk("rst_drop", drop_cnt, 0);
      repeat (3) @(posedge clk50);
      #1;
      rst = 1'b0;
      tick();

      // Single frame at full rate, latency check
      push_frame(32'h01020304, 32'h05060708, 32'h090A0B0C, 15);
      send(32'h01020304, 32'h05060708, 32'h090A0B0C);
      chk("lat_vld", tx_valid, 1);
      chk("lat_dat", tx_data, 8'hA5);
      chk("busy_on", busy, 1);
      wait_idle(100);

      // Same frame under 1-of-3 backpressure
      ready_mode = 1;
      tick();
      push_frame(32'h01020304, 32'h05060708, 32'h090A0B0C, 15);
      send(32'h01020304, 32'h05060708, 32'h090A0B0C);
      wait_idle(200);
      ready_mode = 0;
      tick();

      // Back-to-back frames
      push_frame(32'h01020304, 32'h05060708, 32'h090A0B0C, 15);
      send(32'h01020304, 32'h05060708, 32'h090A0B0C);
      repeat (4) tick();
      push_frame(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 15);
      send(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_idle(100);
      chk("b2b_drop", drop_cnt, 0);

      // Overflow: second triple overwritten by the third
      push_frame(32'h11111111, 32'h12121212, 32'h13131313, 15);
      send(32'h11111111, 32'h12121212, 32'h13131313);
      repeat (2) tick();
      send(32'h21212121, 32'h22222222, 32'h23232323);
      tick();
      push_frame(32'h31313131, 32'h32323232, 32'h33333333, 15);
      send(32'h31313131, 32'h32323232, 32'h33333333);
      chk("ovf_drop", drop_cnt, 1);
      wait_idle(100);
      chk("ovf_drop_after", drop_cnt, 1);

      // Saturation: frame stalled while 300 overwrites arrive
      ready_mode = 2;
      tick();
      push_frame(32'hDEADBEEF, 32'hCAFEF00D, 32'h0BADC0DE, 15);
      send(32'hDEADBEEF, 32'hCAFEF00D, 32'h0BADC0DE);
      for (int i = 0; i <= 300; i++) send(i, ~i, i * 3);
      push_frame(300, ~32'd300, 900, 15);
      chk("sat_drop", drop_cnt, 255);
      chk("sat_busy", busy, 1);
      ready_mode = 0;
      wait_idle(200);
      chk("sat_drop_after", drop_cnt, 255);

      // clr with a pending triple and drop_cnt=5
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr0_drop", drop_cnt, 0);
      ready_mode = 2;
      tick();
      push_frame(32'h44444444, 32'h55555555, 32'h66666666, 15);
      send(32'h44444444, 32'h55555555, 32'h66666666);
      for (int i = 0; i < 6; i++) send(32'hF0 + i, 32'h0, 32'h1);
      chk("clr_pre_drop", drop_cnt, 5);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_drop", drop_cnt, 0);
      chk("clr_busy_inflight", busy, 1);
      ready_mode = 0;
      wait_idle(200);
      chk("clr_busy", busy, 0);
      chk("clr_vld", tx_valid, 0);

      // Reset while payload byte 6 is presented
      push_frame(32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 8);
      send(32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3);
      repeat (2) tick();
      send(32'h77777777, 32'h77777777, 32'h77777777);
      send(32'h88888888, 32'h88888888, 32'h88888888);
      repeat (4) @(posedge clk50);
      #1;
      chk("prerst_dat", tx_data, 8'hB2);
      chk("prerst_drop", drop_cnt, 1);
      #1;
      rst = 1'b1;
      #1;
      chk("arst_vld",  tx_valid, 0);
      chk("arst_busy", busy,     0);
      chk("arst_drop", drop_cnt, 0);
      chk("arst_left", exp_q.size(), 0);
      repeat (2) tick();
      rst = 1'b0;
      tick();
      push_frame(32'h0000_0001, 32'h8000_0000, 32'h7F7F7F7F, 15);
      send(32'h0000_0001, 32'h8000_0000, 32'h7F7F7F7F);
      chk("post_lat_dat", tx_data, 8'hA5);
      wait_idle(100);
      chk("end_vld", tx_valid, 0);

      chk("end_left", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
